// File: rtl/ifmap_spad_window_controller_if.sv
// ---------------------------------------------------------------------------
// ifmap_spad_window_controller_if
//
// Bundles the three streams of the window controller:
//   buffer side : ren_buf (req), buf_valid, buf_row_start, buf_row_end
//   spad side   : wen_spad, spad_waddr
//   PE side     : win_valid, win_start, win_end, r_next_IF
//
// Modports:
//   master - the controller (drives requests, write port and window)
//   slave  - the surrounding buffer/scratchpad/PE environment
// ---------------------------------------------------------------------------
interface ifmap_spad_window_controller_if #(
  parameter int SPAD_ADDR_WIDTH = 4
) ();

  logic                       ren_buf;
  logic                       buf_valid;
  logic                       buf_row_start;
  logic                       buf_row_end;
  logic                       wen_spad;
  logic [SPAD_ADDR_WIDTH-1:0] spad_waddr;
  logic                       win_valid;
  logic [SPAD_ADDR_WIDTH-1:0] win_start;
  logic [SPAD_ADDR_WIDTH-1:0] win_end;
  logic                       r_next_IF;

  modport master (
    output ren_buf, wen_spad, spad_waddr, win_valid, win_start, win_end,
    input  buf_valid, buf_row_start, buf_row_end, r_next_IF
  );

  modport slave (
    input  ren_buf, wen_spad, spad_waddr, win_valid, win_start, win_end,
    output buf_valid, buf_row_start, buf_row_end, r_next_IF
  );

endinterface

// File: rtl/ifmap_spad_window_controller.sv
// ---------------------------------------------------------------------------
// ifmap_spad_window_controller
//
// Fills a circular IFMap scratchpad from the IFMap buffer stream, records
// every complete row as a {start, end, len} descriptor and presents a window
// of k rows to the PE. When the PE is done (r_next_IF) the s oldest rows are
// released one per cycle, freeing their entries so prefetch can continue.
// Writes are only issued while the scratchpad has a free entry, so a live
// entry is never overwritten.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   stall              freezes every register, gates ren_buf/wen_spad
//   clr                synchronous flush to IDLE (beats stall and start)
//   start              latches cfg_k_rows / cfg_stride, accepted in IDLE
//   cfg_k_rows         rows per window (1..MAX_ROWS)
//   cfg_stride         rows released per window (0 -> 1, > k -> k)
//   bus (master)       buffer / scratchpad / PE signals, see the interface
//   occupancy          live scratchpad entries
//   spad_full          occupancy == SPAD_DEPTH
//   err_proto          sticky protocol / deadlock error
// ---------------------------------------------------------------------------
module ifmap_spad_window_controller #(
  parameter int SPAD_ADDR_WIDTH = 4,
  parameter int SPAD_DEPTH      = 12,
  parameter int MAX_ROWS        = 4,
  parameter int ROW_CNT_W       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       clr,
  input  logic                       start,
  input  logic [ROW_CNT_W-1:0]       cfg_k_rows,
  input  logic [ROW_CNT_W-1:0]       cfg_stride,
  ifmap_spad_window_controller_if.master bus,
  output logic [SPAD_ADDR_WIDTH:0]   occupancy,
  output logic                       spad_full,
  output logic                       err_proto
);

  localparam int OCC_W  = SPAD_ADDR_WIDTH + 1;
  localparam int PTR_W  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam int PTR_W1 = PTR_W + 1;

  localparam logic [OCC_W-1:0]           DEPTH_C    = OCC_W'(SPAD_DEPTH);
  localparam logic [SPAD_ADDR_WIDTH-1:0] LAST_ADDR  = SPAD_ADDR_WIDTH'(SPAD_DEPTH - 1);
  localparam logic [ROW_CNT_W-1:0]       MAX_ROWS_C = ROW_CNT_W'(MAX_ROWS);
  localparam logic [PTR_W-1:0]           LAST_PTR   = PTR_W'(MAX_ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, READY, RELEASE} state_t;

  typedef struct packed {
    logic [SPAD_ADDR_WIDTH-1:0] first;
    logic [SPAD_ADDR_WIDTH-1:0] last;
    logic [OCC_W-1:0]           len;
  } desc_t;

  state_t                     state, state_nxt;
  desc_t                      desc_mem [MAX_ROWS];
  logic [PTR_W-1:0]           head, tail, win_last;
  logic [PTR_W1-1:0]          win_sum;
  logic [ROW_CNT_W-1:0]       desc_count, count_nxt;
  logic [ROW_CNT_W-1:0]       k_q, s_q, k_eff, s_eff, rel_cnt;
  logic [SPAD_ADDR_WIDTH-1:0] wptr, row_start_q, start_eff;
  logic [OCC_W-1:0]           row_len;
  logic                       row_open, open_eff;
  logic                       ren, wen, push, pop, win_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Legalise the configuration before it is latched on start.
  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    k_eff = cfg_k_rows;
    if (cfg_k_rows == '0)              k_eff = ROW_CNT_W'(1);
    else if (cfg_k_rows > MAX_ROWS_C)  k_eff = MAX_ROWS_C;
    s_eff = cfg_stride;
    if (cfg_stride == '0)              s_eff = ROW_CNT_W'(1);
    else if (cfg_stride > k_eff)       s_eff = k_eff;
  end

  assign spad_full = (occupancy == DEPTH_C);
  assign ren       = (state != IDLE) && !spad_full && (desc_count < MAX_ROWS_C) && !stall;
  assign wen       = ren && bus.buf_valid;

  assign bus.ren_buf    = ren;
  assign bus.wen_spad   = wen;
  assign bus.spad_waddr = wptr;

  // A beat carrying row_start opens the row at the current address, so a
  // start+end beat is a complete one-entry row.
  assign start_eff = bus.buf_row_start ? wptr : row_start_q;
  assign open_eff  = row_open || bus.buf_row_start;
  assign push      = wen && bus.buf_row_end && open_eff;
  assign pop       = (state == RELEASE) && !stall && (desc_count != '0);
  assign count_nxt = desc_count + ROW_CNT_W'(push) - ROW_CNT_W'(pop);

  always_comb begin
    if (wptr >= start_eff) row_len = OCC_W'(wptr - start_eff) + OCC_W'(1);
    else                   row_len = OCC_W'(wptr) + DEPTH_C - OCC_W'(start_eff) + OCC_W'(1);
  end

  // Index of the k-th oldest descriptor, modulo the FIFO depth.
  assign win_sum  = PTR_W1'(head) + PTR_W1'(k_q - 1'b1);
  assign win_last = (win_sum >= PTR_W1'(MAX_ROWS)) ? PTR_W'(win_sum - PTR_W1'(MAX_ROWS))
                                                   : PTR_W'(win_sum);

  // Window addresses read as 0 whenever no window is presented.
  assign win_valid     = (state == READY);
  assign bus.win_valid = win_valid;
  assign bus.win_start = win_valid ? desc_mem[head].first : '0;
  assign bus.win_end   = win_valid ? desc_mem[win_last].last : '0;

  // Transitions look at the post-push/pop row count so the window appears
  // the cycle right after the k-th row completes.
  always_comb begin
    state_nxt = state;
    if (!stall) begin
      unique case (state)
        IDLE:    if (start) state_nxt = FILL;
        FILL:    if (count_nxt >= k_q) state_nxt = READY;
        READY:   if (bus.r_next_IF) state_nxt = RELEASE;
        RELEASE: if (rel_cnt <= ROW_CNT_W'(1))
                   state_nxt = (count_nxt >= k_q) ? READY : FILL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      row_start_q <= '0;
      row_open    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      desc_count  <= '0;
      k_q         <= '0;
      s_q         <= '0;
      rel_cnt     <= '0;
      occupancy   <= '0;
      err_proto   <= 1'b0;
    end else if (clr) begin
      wptr       <= '0;
      row_open   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      desc_count <= '0;
      rel_cnt    <= '0;
      occupancy  <= '0;
      err_proto  <= 1'b0;
    end else if (!stall) begin
      if (state == IDLE && start) begin
        k_q <= k_eff;
        s_q <= s_eff;
      end

      if (state == READY && bus.r_next_IF) rel_cnt <= s_q;
      else if (state == RELEASE)           rel_cnt <= rel_cnt - 1'b1;

      if (wen) begin
        wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
        if (bus.buf_row_start) begin
          row_start_q <= wptr;
          if (row_open) err_proto <= 1'b1;
        end
        if (bus.buf_row_end) begin
          row_open <= 1'b0;
          if (!open_eff) err_proto <= 1'b1;
        end else if (bus.buf_row_start) begin
          row_open <= 1'b1;
        end
      end

      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      desc_count <= count_nxt;
      occupancy  <= occupancy + OCC_W'(wen) - (pop ? desc_mem[head].len : '0);

      // Scratchpad full of partial data with too few complete rows: no
      // progress is possible until software flushes.
      if (state == FILL && spad_full && desc_count < k_q) err_proto <= 1'b1;
    end
  end

  // NOTE: the descriptor store is not reset; head/tail/desc_count define
  // which entries are live and the window outputs are gated by win_valid.
  always_ff @(posedge clk) begin
    if (push && !clr) desc_mem[tail] <= '{first: start_eff, last: wptr, len: row_len};
  end

endmodule

// File: tb/tb_ifmap_spad_window_controller.sv
// ---------------------------------------------------------------------------
// tb_ifmap_spad_window_controller
//
// Self-checking bench: a behavioural model (queue of row descriptors plus
// occupancy/pointer arithmetic) predicts every output each cycle, with a
// few directed sequences followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_ifmap_spad_window_controller;

  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int MAXR  = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst, stall, clr, start;
  logic [CW-1:0] cfg_k_rows, cfg_stride;
  logic [AW:0]   occupancy;
  logic          spad_full, err_proto;

  always #5 clk = ~clk;

  ifmap_spad_window_controller_if #(.SPAD_ADDR_WIDTH(AW)) bus ();

  ifmap_spad_window_controller #(
    .SPAD_ADDR_WIDTH(AW), .SPAD_DEPTH(DEPTH), .MAX_ROWS(MAXR), .ROW_CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .clr(clr), .start(start),
    .cfg_k_rows(cfg_k_rows), .cfg_stride(cfg_stride), .bus(bus),
    .occupancy(occupancy), .spad_full(spad_full), .err_proto(err_proto)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int first; int last; int len; } row_t;
  row_t rows[$];
  bit   m_active, m_window, m_open, m_err;
  int   m_rel, m_k, m_s, m_wptr, m_occ, m_open_start;

  // stream generator
  int   gen_pos, gen_len, gen_fixed;
  bit   gen_orphan, exp_wen;

  function automatic int new_len();
    return (gen_fixed != 0) ? gen_fixed : int'($urandom_range(1, 3));
  endfunction

  function automatic void model_clear();
    m_active = 0; m_window = 0; m_open = 0; m_err = 0;
    m_rel = 0; m_wptr = 0; m_occ = 0; m_open_start = 0;
    rows.delete();
    gen_pos = 0; gen_len = new_len();
  endfunction

  task automatic drive_beat(input bit valid, input bit orphan, input bit dup);
    bus.buf_valid = valid;
    gen_orphan    = 1'b0;
    if (dup && gen_pos > 0) begin
      gen_pos = 0;
      gen_len = new_len();
    end
    if (orphan && gen_pos == 0) begin
      bus.buf_row_start = 1'b0;
      bus.buf_row_end   = 1'b1;
      gen_orphan        = 1'b1;
    end else begin
      bus.buf_row_start = (gen_pos == 0);
      bus.buf_row_end   = (gen_pos == gen_len - 1);
    end
  endtask

  task automatic compare_outputs();
    bit ren, full;
    full    = (m_occ == DEPTH);
    ren     = m_active && !full && (rows.size() < MAXR) && !stall;
    exp_wen = ren && bus.buf_valid;
    check("ren_buf",    32'(bus.ren_buf),    32'(ren));
    check("wen_spad",   32'(bus.wen_spad),   32'(exp_wen));
    check("spad_waddr", 32'(bus.spad_waddr), m_wptr);
    check("win_valid",  32'(bus.win_valid),  32'(m_window));
    check("win_start",  32'(bus.win_start),  m_window ? rows[0].first : 0);
    check("win_end",    32'(bus.win_end),    m_window ? rows[m_k-1].last : 0);
    check("occupancy",  32'(occupancy),      m_occ);
    check("spad_full",  32'(spad_full),      32'(full));
    check("err_proto",  32'(err_proto),      32'(m_err));
  endtask

  task automatic model_step();
    int   popped, st;
    row_t r;
    if (clr) begin
      model_clear();
      return;
    end
    if (stall) return;
    if (m_active && !m_window && m_rel == 0 && m_occ == DEPTH && rows.size() < m_k) m_err = 1;
    popped = 0;
    if (m_rel > 0 && rows.size() > 0) begin
      popped = rows[0].len;
      void'(rows.pop_front());
    end
    if (exp_wen) begin
      st = m_open_start;
      if (bus.buf_row_start) begin
        if (m_open) m_err = 1;
        m_open = 1; m_open_start = m_wptr; st = m_wptr;
      end
      if (bus.buf_row_end) begin
        if (m_open) begin
          r.first = st; r.last = m_wptr; r.len = ((m_wptr - st + DEPTH) % DEPTH) + 1;
          rows.push_back(r);
          m_open = 0;
        end else m_err = 1;
      end
      m_occ++;
      m_wptr = (m_wptr + 1) % DEPTH;
      if (!gen_orphan) begin
        gen_pos++;
        if (gen_pos == gen_len) begin gen_pos = 0; gen_len = new_len(); end
      end
    end
    m_occ -= popped;
    if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_k = int'(cfg_k_rows);
        if (m_k < 1) m_k = 1;
        if (m_k > MAXR) m_k = MAXR;
        m_s = int'(cfg_stride);
        if (m_s == 0) m_s = 1;
        if (m_s > m_k) m_s = m_k;
      end
    end else if (m_window) begin
      if (bus.r_next_IF) begin m_window = 0; m_rel = m_s; end
    end else if (m_rel > 0) begin
      m_rel--;
      if (m_rel == 0) m_window = (rows.size() >= m_k);
    end else begin
      m_window = (rows.size() >= m_k);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic step();
    #1 compare_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1; drive_beat(1'b0, 1'b0, 1'b0); step(); clr = 1'b0;
  endtask

  task automatic do_start(input int k, input int s);
    cfg_k_rows = CW'(k); cfg_stride = CW'(s); start = 1'b1;
    drive_beat(1'b0, 1'b0, 1'b0); step(); start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; clr = 1'b0; start = 1'b0;
    cfg_k_rows = '0; cfg_stride = '0;
    bus.buf_valid = 1'b0; bus.buf_row_start = 1'b0; bus.buf_row_end = 1'b0;
    bus.r_next_IF = 1'b0;
    gen_fixed = 3;
    model_clear();
    @(negedge clk);
    step();
    rst = 1'b1;
    step();

    // k=3, s=1, rows of 3: window, wrap to full, release
    do_start(3, 1);
    for (int i = 0; i < 40 && !m_window; i++) begin drive_beat(1'b1, 1'b0, 1'b0); step(); end
    check("d1_win_valid", 32'(bus.win_valid), 1);
    check("d1_win_start", 32'(bus.win_start), 0);
    check("d1_win_end",   32'(bus.win_end),   8);
    check("d1_occ",       32'(occupancy),     9);
    for (int i = 0; i < 40 && m_occ < DEPTH; i++) begin drive_beat(1'b1, 1'b0, 1'b0); step(); end
    check("d1_full",      32'(spad_full),      1);
    check("d1_ren_full",  32'(bus.ren_buf),    0);
    check("d1_waddr_wrap",32'(bus.spad_waddr), 0);
    bus.r_next_IF = 1'b1; drive_beat(1'b1, 1'b0, 1'b0); step();
    bus.r_next_IF = 1'b0; drive_beat(1'b1, 1'b0, 1'b0); step();
    check("d1_occ_rel",   32'(occupancy),      9);
    check("d1_ren_again", 32'(bus.ren_buf),    1);
    check("d1_waddr_0",   32'(bus.spad_waddr), 0);
    check("d1_win_start2",32'(bus.win_start),  3);
    check("d1_win_end2",  32'(bus.win_end),    11);

    // k=2, s=2 with a 5-cycle stall during FILL
    do_clr();
    do_start(2, 2);
    for (int i = 0; i < 2; i++) begin drive_beat(1'b1, 1'b0, 1'b0); step(); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin drive_beat(1'b1, 1'b0, 1'b0); step(); end
    check("d2_stall_waddr", 32'(bus.spad_waddr), 2);
    check("d2_stall_occ",   32'(occupancy),      2);
    stall = 1'b0;
    drive_beat(1'b1, 1'b0, 1'b0); step();
    check("d2_resume_waddr", 32'(bus.spad_waddr), 3);
    for (int i = 0; i < 40 && !m_window; i++) begin drive_beat(1'b1, 1'b0, 1'b0); step(); end
    check("d2_win_valid", 32'(bus.win_valid), 1);
    bus.r_next_IF = 1'b1; drive_beat(1'b1, 1'b0, 1'b0); step();
    bus.r_next_IF = 1'b0;
    for (int i = 0; i < 6; i++) begin drive_beat(1'b1, 1'b0, 1'b0); step(); end

    // orphan row_end, then clr
    do_clr();
    do_start(1, 1);
    drive_beat(1'b1, 1'b1, 1'b0); step();
    check("d3_err",       32'(err_proto),     1);
    check("d3_no_window", 32'(bus.win_valid), 0);
    check("d3_occ",       32'(occupancy),     1);
    do_clr();
    check("d3_clr_err",   32'(err_proto),     0);
    check("d3_clr_occ",   32'(occupancy),     0);
    check("d3_clr_idle",  32'(bus.ren_buf),   0);

    // randomized traffic
    gen_fixed = 0;
    for (int c = 0; c < 3000; c++) begin
      stall         = ($urandom_range(0, 9) == 0);
      clr           = ($urandom_range(0, 299) == 0);
      start         = ($urandom_range(0, 3) == 0);
      cfg_k_rows    = CW'($urandom_range(1, 4));
      cfg_stride    = CW'($urandom_range(0, 7));
      bus.r_next_IF = ($urandom_range(0, 2) == 0);
      drive_beat($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 149) == 0);
      step();
    end
    stall = 1'b0; clr = 1'b0; start = 1'b0; bus.r_next_IF = 1'b0;

    // asynchronous reset while a window is presented
    do_clr();
    do_start(3, 1);
    for (int i = 0; i < 60 && !m_window; i++) begin drive_beat(1'b1, 1'b0, 1'b0); step(); end
    check("d4_ready", 32'(bus.win_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("rst_ren_buf",   32'(bus.ren_buf),    0);
    check("rst_wen_spad",  32'(bus.wen_spad),   0);
    check("rst_waddr",     32'(bus.spad_waddr), 0);
    check("rst_win_valid", 32'(bus.win_valid),  0);
    check("rst_win_start", 32'(bus.win_start),  0);
    check("rst_win_end",   32'(bus.win_end),    0);
    check("rst_occ",       32'(occupancy),      0);
    check("rst_full",      32'(spad_full),      0);
    check("rst_err",       32'(err_proto),      0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    drive_beat(1'b0, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
